// File: rtl/btn_pkg.sv
// Shared button-event types: FSM state encoding and a small sizing helper.
// Used by btn_event and the top-level UI decode.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      LONG
   } btn_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_event.sv
// Debounced button level to press/release/click/long/repeat pulses.
// Auto-repeat is built only when BTN_EVENT_REPEAT_EN is defined.
module btn_event
   import btn_pkg::*;
#(
   parameter int LongCount   = 1000,
   parameter int RepeatCount = 250
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o,
   output logic release_o,
   output logic click_o,
   output logic long_o,
   output logic repeat_o,
   output logic held_o
);

   localparam int CntW = $clog2(max_int(LongCount, RepeatCount));
   localparam logic [CntW-1:0] LongLast = CntW'(LongCount - 1);
`ifdef BTN_EVENT_REPEAT_EN
   localparam logic [CntW-1:0] RepLast = CntW'(RepeatCount - 1);
`endif

   btn_state_e      state;
   logic [CntW-1:0] cnt;

   assign held_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         press_o   <= 1'b0;
         release_o <= 1'b0;
         click_o   <= 1'b0;
         long_o    <= 1'b0;
         repeat_o  <= 1'b0;
      end else begin
         press_o   <= 1'b0;
         release_o <= 1'b0;
         click_o   <= 1'b0;
         long_o    <= 1'b0;
         repeat_o  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (btn_i) begin
                  state   <= PRESS;
                  cnt     <= '0;
                  press_o <= 1'b1;
               end
            end
            PRESS: begin
               // release wins over a long press landing on the same edge
               if (!btn_i) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  release_o <= 1'b1;
                  click_o   <= 1'b1;
               end else if (cnt == LongLast) begin
                  state  <= LONG;
                  cnt    <= '0;
                  long_o <= 1'b1;
               end else begin
                  cnt <= cnt + CntW'(1);
               end
            end
            LONG: begin
               if (!btn_i) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  release_o <= 1'b1;
               end else begin
`ifdef BTN_EVENT_REPEAT_EN
                  if (cnt == RepLast) begin
                     repeat_o <= 1'b1;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt + CntW'(1);
                  end
`else
                  cnt <= '0;
`endif
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: directed scenarios plus random button runs
// checked against an age-since-press reference model.
module tb_btn_event;

   localparam int L = 8;
   localparam int R = 4;
`ifdef BTN_EVENT_REPEAT_EN
   localparam bit RepEn = 1'b1;
`else
   localparam bit RepEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic btn;
   logic press_o, release_o, click_o, long_o, repeat_o, held_o;

   int passed = 0;
   int total  = 0;

   bit         m_active;
   int         m_age;
   logic [5:0] exp_v;

   btn_event #(.LongCount(L), .RepeatCount(R)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .btn_i    (btn),
      .press_o  (press_o),
      .release_o(release_o),
      .click_o  (click_o),
      .long_o   (long_o),
      .repeat_o (repeat_o),
      .held_o   (held_o)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs();
      return {press_o, release_o, click_o, long_o, repeat_o, held_o};
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      exp_v    = '0;
   endtask

   // Drive one sample, take one edge, and predict the outputs from the
   // number of cycles elapsed since the press pulse.
   task automatic cycle(input logic b);
      logic p, rl, c, lg, rp;
      btn = b;
      @(posedge clk);
      {p, rl, c, lg, rp} = '0;
      if (!m_active) begin
         if (b) begin
            m_active = 1'b1;
            m_age    = 0;
            p        = 1'b1;
         end
      end else begin
         m_age++;
         if (!b) begin
            rl       = 1'b1;
            c        = (m_age <= L);
            m_active = 1'b0;
         end else if (m_age == L) begin
            lg = 1'b1;
         end else if (RepEn && m_age > L && (m_age - L) % R == 0) begin
            rp = 1'b1;
         end
      end
      exp_v = {p, rl, c, lg, rp, m_active};
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn = 1'b1;
      #3;
      total++;
      if (obs() !== 6'b0)
         $display("FAIL reset_async: got %b want %b", obs(), 6'b0);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (obs() !== 6'b0)
         $display("FAIL reset_held: got %b want %b", obs(), 6'b0);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(1'b1);
      total++;
      if (obs() !== exp_v || press_o !== 1'b1 || held_o !== 1'b1)
         $display("FAIL reset_press: got %b want %b", obs(), exp_v);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0);
         total++;
         if (obs() !== exp_v)
            $display("FAIL reset_tail cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
      end
   endtask

   task automatic test_short_click();
      int n_press = 0, n_rel = 0, n_click = 0, n_long = 0, n_held = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(i < 3);
         total++;
         if (obs() !== exp_v)
            $display("FAIL click cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
         n_press += press_o;
         n_rel   += release_o;
         n_click += (release_o & click_o);
         n_long  += long_o;
         n_held  += held_o;
      end
      total++;
      if (n_press != 1 || n_rel != 1 || n_click != 1 || n_long != 0 || n_held != 3)
         $display("FAIL click_counts: got p%0d r%0d c%0d l%0d h%0d want p1 r1 c1 l0 h3",
                  n_press, n_rel, n_click, n_long, n_held);
      else passed++;
   endtask

   task automatic test_long_repeat();
      int long_at = -1, rel_at = -1, n_rep = 0, n_click = 0;
      for (int i = 0; i < 25; i++) begin
         cycle(i < 22);
         total++;
         if (obs() !== exp_v)
            $display("FAIL long cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
         if (long_o) long_at = i;
         if (release_o) rel_at = i;
         n_rep   += repeat_o;
         n_click += click_o;
      end
      total++;
      if (long_at != 8 || rel_at != 22 || n_click != 0 || n_rep != (RepEn ? 3 : 0))
         $display("FAIL long_summary: got long@%0d rel@%0d rep%0d click%0d want long@8 rel@22 rep%0d click0",
                  long_at, rel_at, n_rep, n_click, RepEn ? 3 : 0);
      else passed++;
   endtask

   task automatic test_release_at_boundary();
      for (int i = 0; i < 11; i++) begin
         cycle(i < L);
         total++;
         if (obs() !== exp_v)
            $display("FAIL boundary cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
         if (i == L) begin
            total++;
            if ({release_o, click_o, long_o} !== 3'b110)
               $display("FAIL boundary_release: got %b want 110",
                        {release_o, click_o, long_o});
            else passed++;
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1);
         total++;
         if (obs() !== exp_v)
            $display("FAIL midhold cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      total++;
      if (obs() !== 6'b0)
         $display("FAIL midhold_reset: got %b want %b", obs(), 6'b0);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(i < 10);
         total++;
         if (obs() !== exp_v)
            $display("FAIL repress cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic b = 1'b0;
      int   run = 0;
      for (int i = 0; i < 600; i++) begin
         if (run == 0) begin
            b   = ~b;
            run = $urandom_range(1, 25);
         end
         run--;
         cycle(b);
         total++;
         if (obs() !== exp_v)
            $display("FAIL random cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0);
         total++;
         if (obs() !== exp_v)
            $display("FAIL random_tail cyc %0d: got %b want %b", i, obs(), exp_v);
         else passed++;
      end
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      model_reset();
      test_reset();
      test_short_click();
      test_long_repeat();
      test_release_at_boundary();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
